// File: rtl/rv32i_bus_decoder_pkg.sv
// Shared types for the rv32i memory-map decoder: FSM states, fault codes and
// the one-hot to index helper used to pick the selected target's read data.
package rv32i_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DONE  = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam int unsigned MAX_REGIONS = 32;

  typedef logic [1:0] fault_t;
  localparam fault_t FLT_NONE    = 2'd0;
  localparam fault_t FLT_ILLEGAL = 2'd1;
  localparam fault_t FLT_TIMEOUT = 2'd2;

  // Shifts rather than indexes so the loop never needs a variable bit-select.
  function automatic int unsigned onehot_idx(input logic [MAX_REGIONS-1:0] oh);
    logic [MAX_REGIONS-1:0] v;
    int unsigned            idx;
    v   = oh;
    idx = 0;
    for (int unsigned i = 0; i < MAX_REGIONS; i++) begin
      if (v[0]) idx = i;
      v = v >> 1;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rv32i_bus_decoder_if.sv
// Core-side request/response and target-side select/ack signals of the decoder.
// slave: the decoder's view; master: the core plus targets driving it.
interface rv32i_bus_decoder_if #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned REGIONS = 4
);
  logic                     read_i;
  logic                     write_i;
  logic [XLEN-1:0]          addr_i;
  logic [XLEN-1:0]          data_i;
  logic [XLEN/8-1:0]        be_i;
  logic                     ready_o;
  logic [XLEN-1:0]          data_o;
  logic                     illegal_access_o;
  logic                     timeout_o;
  logic [REGIONS-1:0]       data_region_o;

  logic [REGIONS-1:0]       sel_o;
  logic [XLEN-1:0]          addr_o;
  logic                     we_o;
  logic                     re_o;
  logic [XLEN-1:0]          wdata_o;
  logic [XLEN/8-1:0]        be_o;
  logic [REGIONS*XLEN-1:0]  rdata_i;
  logic [REGIONS-1:0]       ack_i;

  modport slave (
    input  read_i, write_i, addr_i, data_i, be_i, rdata_i, ack_i,
    output ready_o, data_o, illegal_access_o, timeout_o, data_region_o,
           sel_o, addr_o, we_o, re_o, wdata_o, be_o
  );

  modport master (
    output read_i, write_i, addr_i, data_i, be_i, rdata_i, ack_i,
    input  ready_o, data_o, illegal_access_o, timeout_o, data_region_o,
           sel_o, addr_o, we_o, re_o, wdata_o, be_o
  );
endinterface

// File: rtl/rv32i_bus_decoder_region_match.sv
// Single address window comparator: inclusive base, exclusive end, unsigned.
module rv32i_region_match #(
  parameter int unsigned     XLEN  = 32,
  parameter logic [XLEN-1:0] BASE  = '0,
  parameter logic [XLEN-1:0] LIMIT = '0
) (
  input  logic [XLEN-1:0] addr,
  output logic            hit,
  output logic [XLEN-1:0] offset
);
  assign hit    = (addr >= BASE) && (addr < LIMIT);
  assign offset = addr - BASE;
endmodule

// File: rtl/rv32i_bus_decoder.sv
// N-region memory-map decoder and single-outstanding transaction sequencer.
// Define RV32I_BUS_TIMEOUT_EN to build the WAIT-state watchdog (timeout_o).
module rv32i_bus_decoder
  import rv32i_bus_pkg::*;
#(
  parameter int unsigned             XLEN        = 32,
  parameter int unsigned             REGIONS     = 4,
  parameter logic [REGIONS*XLEN-1:0] REGION_BASE = {32'h0005_0000, 32'h0002_0000,
                                                    32'h0001_0000, 32'h0000_0000},
  parameter logic [REGIONS*XLEN-1:0] REGION_END  = {32'h0005_0200, 32'h0004_0000,
                                                    32'h0001_0800, 32'h0000_0040},
  parameter int unsigned             TIMEOUT     = 16
) (
  input logic               clk_i,
  input logic               rst_ni,
  rv32i_bus_decoder_if.slave bus
);
  localparam int unsigned IDX_W = (REGIONS > 1) ? $clog2(REGIONS) : 1;

  if (TIMEOUT < 2 || REGIONS == 0 || REGIONS > MAX_REGIONS) begin : g_bad_cfg
    $error("rv32i_bus_decoder: TIMEOUT must be >= 2 and REGIONS in 1..32");
  end

  logic [REGIONS-1:0] hit_vec;
  logic [XLEN-1:0]    off_vec   [REGIONS];
  logic [XLEN-1:0]    off_chain [REGIONS+1];
  logic [XLEN-1:0]    rdata_arr [REGIONS];
  logic [REGIONS-1:0] hit_oh;
  logic [XLEN-1:0]    hit_off;
  logic [IDX_W-1:0]   sel_idx;

  for (genvar k = 0; k < REGIONS; k++) begin : g_region
    rv32i_region_match #(
      .XLEN  (XLEN),
      .BASE  (REGION_BASE[k*XLEN +: XLEN]),
      .LIMIT (REGION_END[k*XLEN +: XLEN])
    ) u_match (
      .addr   (bus.addr_i),
      .hit    (hit_vec[k]),
      .offset (off_vec[k])
    );
    assign off_chain[k+1] = off_chain[k] | (off_vec[k] & {XLEN{hit_oh[k]}});
    assign rdata_arr[k]   = bus.rdata_i[k*XLEN +: XLEN];
  end

  // Lowest-index window wins on overlap: isolate the least significant hit.
  assign hit_oh       = hit_vec & (~hit_vec + REGIONS'(1));
  assign off_chain[0] = '0;
  assign hit_off      = off_chain[REGIONS];
  assign sel_idx      = IDX_W'(onehot_idx(MAX_REGIONS'(bus.sel_o)));

  state_t state_q;
  fault_t fault_q;
  logic   ack_hit;
  logic   wd_expire;

  assign ack_hit = |(bus.ack_i & bus.sel_o);

`ifdef RV32I_BUS_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT);
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || state_q != WAIT) cnt_q <= '0;
    else                            cnt_q <= cnt_q + CNT_W'(1);
  end

  assign wd_expire     = (cnt_q == CNT_W'(TIMEOUT - 1));
  assign bus.timeout_o = (fault_q == FLT_TIMEOUT);
`else
  assign wd_expire     = 1'b0;
  assign bus.timeout_o = 1'b0;
`endif

  assign bus.illegal_access_o = (fault_q == FLT_ILLEGAL);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q           <= IDLE;
      fault_q           <= FLT_NONE;
      bus.ready_o       <= 1'b0;
      bus.data_o        <= '0;
      bus.data_region_o <= '0;
      bus.sel_o         <= '0;
      bus.addr_o        <= '0;
      bus.we_o          <= 1'b0;
      bus.re_o          <= 1'b0;
      bus.wdata_o       <= '0;
      bus.be_o          <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.read_i || bus.write_i) begin
            bus.data_region_o <= hit_oh;
            if (hit_oh == '0 || (bus.read_i && bus.write_i)) begin
              state_q     <= FAULT;
              fault_q     <= FLT_ILLEGAL;
              bus.ready_o <= 1'b1;
              if (bus.read_i) bus.data_o <= '0;
            end else begin
              state_q     <= WAIT;
              bus.sel_o   <= hit_oh;
              bus.addr_o  <= hit_off;
              bus.re_o    <= bus.read_i;
              bus.we_o    <= bus.write_i;
              bus.wdata_o <= bus.data_i;
              bus.be_o    <= bus.be_i;
            end
          end
        end
        WAIT: begin
          // Ack beats an expiring watchdog in the same cycle.
          if (ack_hit || wd_expire) begin
            bus.ready_o <= 1'b1;
            bus.sel_o   <= '0;
            bus.addr_o  <= '0;
            bus.re_o    <= 1'b0;
            bus.we_o    <= 1'b0;
            bus.wdata_o <= '0;
            bus.be_o    <= '0;
            if (ack_hit) begin
              state_q <= DONE;
              if (bus.re_o) bus.data_o <= rdata_arr[sel_idx];
            end else begin
              state_q <= FAULT;
              fault_q <= FLT_TIMEOUT;
              if (bus.re_o) bus.data_o <= '0;
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          fault_q     <= FLT_NONE;
          bus.ready_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_bus_decoder.sv
// Randomised transaction-level bench for rv32i_bus_decoder with a cycle-by-cycle
// expected-output model derived from the memory map and transaction timing rules.
module tb_rv32i_bus_decoder;
  localparam int unsigned XLEN    = 32;
  localparam int unsigned REGIONS = 4;
  localparam int unsigned TIMEOUT = 16;
  localparam logic [REGIONS*XLEN-1:0] RB = {32'h0005_0000, 32'h0002_0000,
                                            32'h0001_0000, 32'h0000_0000};
  localparam logic [REGIONS*XLEN-1:0] RE = {32'h0005_0200, 32'h0004_0000,
                                            32'h0001_0800, 32'h0000_0040};

  logic [31:0] base_a [4] = '{32'h0, 32'h10000, 32'h20000, 32'h50000};
  logic [31:0] end_a  [4] = '{32'h40, 32'h10800, 32'h40000, 32'h50200};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rv32i_bus_decoder_if #(.XLEN(XLEN), .REGIONS(REGIONS)) bus ();

  rv32i_bus_decoder #(
    .XLEN(XLEN), .REGIONS(REGIONS), .REGION_BASE(RB), .REGION_END(RE), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int vecs = 0;
  int errs = 0;
  bit chk_en = 1'b0;

  logic        e_ready, e_ill, e_to, e_re, e_we;
  logic [31:0] e_data, e_addr, e_wdata;
  logic [3:0]  e_region, e_sel, e_be;
  logic [31:0] md;
  logic [3:0]  mreg;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready",   32'(bus.ready_o),          32'(e_ready));
      chk("illegal", 32'(bus.illegal_access_o), 32'(e_ill));
      chk("timeout", 32'(bus.timeout_o),        32'(e_to));
      chk("data_o",  bus.data_o,                e_data);
      chk("region",  32'(bus.data_region_o),    32'(e_region));
      chk("sel",     32'(bus.sel_o),            32'(e_sel));
      chk("addr_o",  bus.addr_o,                e_addr);
      chk("re",      32'(bus.re_o),             32'(e_re));
      chk("we",      32'(bus.we_o),             32'(e_we));
      chk("wdata",   bus.wdata_o,               e_wdata);
      chk("be_o",    32'(bus.be_o),             32'(e_be));
    end
  end

  function automatic int region_of(input logic [31:0] a);
    for (int k = 0; k < 4; k++)
      if (a >= base_a[k] && a < end_a[k]) return k;
    return -1;
  endfunction

  task automatic set_quiet();
    e_ready = 1'b0; e_ill = 1'b0; e_to = 1'b0; e_re = 1'b0; e_we = 1'b0;
    e_sel = '0; e_addr = '0; e_wdata = '0; e_be = '0;
    e_data = md; e_region = mreg;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_noise(input logic [3:0] mask);
    bus.ack_i = 4'($urandom) & ~mask;
    for (int k = 0; k < 4; k++) bus.rdata_i[k*32 +: 32] = $urandom;
  endtask

  task automatic idle_cycle();
    tick();
    set_quiet();
    bus.read_i = 1'b0; bus.write_i = 1'b0;
    drive_noise(4'h0);
  endtask

  // One request from cycle 0 to its ready_o cycle; ack_at is the WAIT cycle
  // (1 = first) in which the selected target acks, rst_at>0 pulls reset then.
  task automatic do_txn(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be,
                        input int ack_at, input int rst_at,
                        input bit frc, input logic [31:0] fval);
    int          r, lat;
    logic [3:0]  oh;
    logic [31:0] off, cap;
    bit          to;
    r   = region_of(a);
    oh  = (r < 0) ? 4'h0 : 4'(1 << r);
    off = (r < 0) ? 32'h0 : a - base_a[r];
    tick();
    set_quiet();
    bus.read_i = rd; bus.write_i = wr; bus.addr_i = a; bus.data_i = d; bus.be_i = be;
    drive_noise(4'h0);
    if (r < 0 || (rd && wr)) begin
      tick();
      if (rd) md = '0;
      mreg = oh;
      set_quiet();
      e_ready = 1'b1; e_ill = 1'b1;
      drive_noise(4'h0);
      return;
    end
    to  = 1'b0;
    lat = ack_at + 1;
`ifdef RV32I_BUS_TIMEOUT_EN
    if (ack_at > int'(TIMEOUT)) begin to = 1'b1; lat = TIMEOUT + 1; end
`endif
    mreg = oh;
    cap  = md;
    for (int c = 1; c < lat; c++) begin
      tick();
      set_quiet();
      e_sel = oh; e_addr = off; e_re = rd; e_we = wr; e_wdata = d; e_be = be;
      drive_noise(oh);
      bus.addr_i = $urandom; bus.data_i = $urandom; bus.be_i = 4'($urandom);
      if (c == rst_at) begin
        bus.read_i = 1'b0; bus.write_i = 1'b0; rst_n = 1'b0;
        tick();
        rst_n = 1'b1; md = '0; mreg = '0;
        set_quiet();
        bus.ack_i = oh;
        tick();
        set_quiet();
        bus.ack_i = '0;
        return;
      end
      if (c == ack_at) begin
        bus.ack_i = bus.ack_i | oh;
        if (frc) bus.rdata_i[r*32 +: 32] = fval;
        cap = bus.rdata_i[r*32 +: 32];
      end
    end
    tick();
    if (rd) md = to ? 32'h0 : cap;
    set_quiet();
    e_ready = 1'b1; e_to = to;
    drive_noise(4'h0);
  endtask

  logic [31:0] bnd [9] = '{32'h3F, 32'h40, 32'h107FF, 32'h10800, 32'h3FFFF,
                           32'h40000, 32'h501FF, 32'h50200, 32'hFFFF_FFFF};

  initial begin
    rst_n = 1'b0;
    bus.read_i = 1'b0; bus.write_i = 1'b0; bus.addr_i = '0; bus.data_i = '0;
    bus.be_i = '0; bus.ack_i = '0; bus.rdata_i = '0;
    md = '0; mreg = '0;
    set_quiet();
    tick();
    chk_en = 1'b1;
    tick();
    set_quiet();
    rst_n = 1'b1;
    idle_cycle();

    chk("lit_model_region", 32'(region_of(32'h10004)), 32'd1);
    do_txn(1'b1, 1'b0, 32'h10004, 32'h0, 4'hF, 3, 0, 1'b1, 32'hDEADBEEF);
    chk("lit_rd_data",   bus.data_o, 32'hDEADBEEF);
    chk("lit_rd_region", 32'(bus.data_region_o), 32'h2);

    do_txn(1'b0, 1'b1, 32'h20010, 32'h12345678, 4'b0011, 1, 0, 1'b0, 32'h0);
    chk("lit_wr_data_held", bus.data_o, 32'hDEADBEEF);
    chk("lit_wr_region",    32'(bus.data_region_o), 32'h4);

    do_txn(1'b1, 1'b0, 32'h3000_0000, 32'h0, 4'hF, 2, 0, 1'b0, 32'h0);
    chk("lit_ill_flag",   32'(bus.illegal_access_o), 32'h1);
    chk("lit_ill_data",   bus.data_o, 32'h0);
    chk("lit_ill_region", 32'(bus.data_region_o), 32'h0);
    idle_cycle();

    do_txn(1'b1, 1'b1, 32'h0, 32'h0, 4'hF, 2, 0, 1'b0, 32'h0);
    chk("lit_both_flag", 32'(bus.illegal_access_o), 32'h1);
    chk("lit_both_data", bus.data_o, 32'h0);
    idle_cycle();

    do_txn(1'b1, 1'b0, 32'h50000, 32'h0, 4'hF, 100, 0, 1'b1, 32'hCAFEF00D);
`ifdef RV32I_BUS_TIMEOUT_EN
    chk("lit_to_flag", 32'(bus.timeout_o), 32'h1);
    chk("lit_to_data", bus.data_o, 32'h0);
`else
    chk("lit_to_flag", 32'(bus.timeout_o), 32'h0);
    chk("lit_to_data", bus.data_o, 32'hCAFEF00D);
`endif
    idle_cycle();

    foreach (bnd[i]) do_txn(1'b1, 1'b0, bnd[i], 32'h0, 4'hF, 2, 0, 1'b0, 32'h0);
    do_txn(1'b1, 1'b0, 32'h20004, 32'h0, 4'hF, TIMEOUT, 0, 1'b0, 32'h0);
    do_txn(1'b0, 1'b1, 32'h20008, 32'h55AA55AA, 4'hC, TIMEOUT + 1, 0, 1'b0, 32'h0);

    do_txn(1'b1, 1'b0, 32'h20000, 32'h0, 4'hF, 10, 5, 1'b0, 32'h0);
    chk("lit_rst_data",   bus.data_o, 32'h0);
    chk("lit_rst_region", 32'(bus.data_region_o), 32'h0);
    do_txn(1'b1, 1'b0, 32'h10000, 32'h0, 4'hF, 2, 0, 1'b1, 32'hA5A5A5A5);
    chk("lit_post_rst_data", bus.data_o, 32'hA5A5A5A5);

    for (int i = 0; i < 300; i++) begin
      int          sel, k, rw, ack, rst_at;
      logic [31:0] a;
      sel = $urandom_range(0, 9);
      if (sel < 7) begin
        k = $urandom_range(0, 3);
        a = base_a[k] + ($urandom % (end_a[k] - base_a[k]));
      end else if (sel < 9) begin
        a = $urandom;
      end else begin
        a = end_a[$urandom_range(0, 3)];
      end
      rw = $urandom_range(0, 9);
`ifdef RV32I_BUS_TIMEOUT_EN
      ack = $urandom_range(1, 20);
`else
      ack = $urandom_range(1, 12);
`endif
      rst_at = ($urandom_range(0, 29) == 0) ? $urandom_range(1, 3) : 0;
      do_txn(rw < 5 || rw == 9, rw >= 5, a, $urandom, 4'($urandom), ack, rst_at, 1'b0, 32'h0);
      repeat ($urandom_range(0, 2)) idle_cycle();
    end

    idle_cycle();
    idle_cycle();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
